joy_serial_multi: RTL and testbench
===================================

Name: joy_serial_multi

Overview:
- Parametrised successor to the fixed two-player DB15 serial joystick reader.
- Drives a 74HC165-style shift chain: generates the load pulse and shift clock, then deserialises PLAYERS x BITS buttons from one data line.
- Adds per-player debounce, disconnect detection and a frame-valid strobe.
- Sits between the UserIO pins and the joystick mux in the emu top level.

Parameters:
- PLAYERS, 2, number of controllers on the chain (1..4).
- BITS, 12, buttons per controller (1..16); output bits at BITS and above are forced 0.
- CLK_DIV, 32, clk cycles per tick (>=2).
- GAP_TICKS, 64, idle ticks between frames (>=1).
- DEBOUNCE, 2, consecutive identical frames required before an output update (1..7; 1 = no debounce).
- ACTIVE_LOW, 1, 1 = a low joy_data bit means pressed.

Ports:
- clk, in, 1, system clock, 40-50 MHz.
- reset_n, in, 1, asynchronous active-low reset.
- enable, in, 1, 1 = run frames; 0 = park after the current frame.
- joy_data, in, 1, serial data from the chain (asynchronous; double-flopped internally).
- joy_clk, out, 1, shift clock to the chain.
- joy_load, out, 1, parallel load to the chain, active low.
- joystick, out, PLAYERS*16, debounced buttons; player p occupies bits [p*16+15 : p*16].
- present, out, PLAYERS, 1 = controller p detected.
- valid, out, 1, one-clk strobe after each frame's LATCH.

Behaviour:
- Reset values (async on reset_n low): joy_clk=1, joy_load=1, joystick=0, present=0, valid=0, state=IDLE, all counters and debounce registers 0.
- Tick generator: free-running counter 0..CLK_DIV-1; a tick fires when it wraps. Counter is cleared on entry to LOAD so frames are tick-aligned.
- joy_data passes through a 2-flop synchroniser. All sampling uses the synchronised value, so there is 2 clk of input latency.
- FSM states: IDLE, LOAD, SHIFT, LATCH, GAP.
- IDLE: joy_clk=1, joy_load=1. Goes to LOAD on the first clk with enable=1.
- LOAD: joy_load=0 for 2 ticks, joy_clk=1. Then to SHIFT with bit index i=0.
- SHIFT: each bit lasts 2 ticks.
  - Phase 0: joy_clk=0; on the closing tick sample raw[i].
  - Phase 1: joy_clk=1; the rising edge advances the chain.
  - After i = PLAYERS*BITS-1 completes phase 1, go to LATCH.
- Bit mapping: raw[i] belongs to player i/BITS, button i%BITS. Bit 0 is present on joy_data immediately after the load.
- Decode: dec = ACTIVE_LOW ? ~raw : raw.
- LATCH (exactly 1 clk), per player p:
  - present[p] <= ~&dec_p. All BITS asserted means a stuck-low or absent line, so present=0.
  - If dec_p equals the previous frame's dec_p, cnt_p <= min(cnt_p+1, DEBOUNCE-1); otherwise cnt_p <= 0.
  - The previous-frame register is updated with dec_p.
  - joystick_p <= dec_p (zero-extended to 16) when the new cnt_p == DEBOUNCE-1 and the player is present. Otherwise joystick_p holds.
  - If not present, joystick_p <= 0 immediately, regardless of debounce.
- valid=1 for the clk following LATCH; joystick and present are stable at that point.
- GAP: joy_clk=1, joy_load=1 for GAP_TICKS ticks. Then LOAD if enable=1, otherwise IDLE.
- enable falling mid-frame: the current frame completes, including LATCH and valid; the FSM then parks in IDLE with outputs held.
- reset_n asserted mid-frame: every output takes its reset value at once. After release, the first frame starts from LOAD on the first enabled clk.
- Frame length in clk: CLK_DIV*(2 + 2*PLAYERS*BITS + GAP_TICKS) + 1.
- Widths: bit index is clog2(PLAYERS*BITS) bits; debounce counters are 3 bits.

Test Plan (PLAYERS=2, BITS=12, CLK_DIV=4, GAP_TICKS=8, DEBOUNCE=2, ACTIVE_LOW=1):
- Reset: hold reset_n=0 -> joy_clk=1, joy_load=1, joystick=0, present=2'b00, valid=0. Release with enable=1 -> joy_load low for exactly 8 clk, then 24 joy_clk low/high pulses, each phase 4 clk.
- Data path: model drives P1 bits 0,4 low and P2 bit 11 low, everything else high, for two frames. After frame 1 joystick=0. After frame 2 valid pulses and joystick[15:0]=16'h0011, joystick[31:16]=16'h0800, present=2'b11. Frame period is 233 clk.
- Debounce: P1 alternates 16'h0001 and 16'h0002 on successive frames -> joystick[15:0] never changes. Then two identical 16'h0002 frames -> joystick[15:0]=16'h0002.
- Disconnect: joy_data tied 0 -> after the next LATCH present=2'b00 and joystick=0 with no debounce delay. joy_data restored with all bits high -> present=2'b11 after 1 frame, joystick=0.
- enable dropped during SHIFT bit 10 -> the frame completes, valid pulses once, FSM holds IDLE with joy_clk=1 and joy_load=1. Re-asserting enable -> LOAD begins on the next clk.
- reset_n pulsed low for 1 clk mid-SHIFT -> outputs return to reset values immediately. Restart produces a complete, correctly aligned 24-bit frame.

Source files
------------

// File: rtl/joy_serial_multi.sv
// Serial joystick reader for a 74HC165-style shift chain.
// Deserialises PLAYERS x BITS buttons, then applies debounce and disconnect detection.
module joy_serial_multi #(
  parameter int PLAYERS    = 2,
  parameter int BITS       = 12,
  parameter int CLK_DIV    = 32,
  parameter int GAP_TICKS  = 64,
  parameter int DEBOUNCE   = 2,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  joy_data,
  output logic                  joy_clk,
  output logic                  joy_load,
  output logic [PLAYERS*16-1:0] joystick,
  output logic [PLAYERS-1:0]    present,
  output logic                  valid
);

  localparam int NB = PLAYERS * BITS;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW = $clog2(GAP_TICKS + 2);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [2:0] DEB_MAX = 3'(DEBOUNCE - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    LATCH,
    GAP
  } state_t;

  state_t          state_q, state_d;
  logic            phase_q, phase_d;
  logic [IW-1:0]   bit_q, bit_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [DW-1:0]   div_q;
  logic            tick;
  logic            clr_div;
  logic            sample;
  logic [1:0]      data_sync;
  logic [NB-1:0]   raw_q;
  logic [NB-1:0]   dec;

  logic [BITS-1:0] prev_q  [PLAYERS];
  logic [2:0]      cnt_q   [PLAYERS];
  logic [BITS-1:0] dec_p   [PLAYERS];
  logic [2:0]      cnt_new [PLAYERS];
  logic [PLAYERS-1:0] pres_new;

  assign tick    = (div_q == DW'(CLK_DIV - 1));
  assign clr_div = (state_q == LATCH) || ((state_d == LOAD) && (state_q != LOAD));
  assign dec     = ACTIVE_LOW ? ~raw_q : raw_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_sync <= '0;
      div_q     <= '0;
    end else begin
      data_sync <= {data_sync[0], joy_data};
      if (clr_div || tick) div_q <= '0;
      else                 div_q <= div_q + DW'(1);
    end
  end

  // Frame sequencer; LOAD and GAP share the tick counter tcnt.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    tcnt_d  = tcnt_q;
    sample  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = LOAD;
          tcnt_d  = '0;
        end
      end
      LOAD: begin
        if (tick) begin
          if (tcnt_q == TW'(1)) begin
            state_d = SHIFT;
            phase_d = 1'b0;
            bit_d   = '0;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!phase_q) begin
            sample  = 1'b1;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (bit_q == IW'(NB - 1)) state_d = LATCH;
            else                      bit_d   = bit_q + IW'(1);
          end
        end
      end
      LATCH: begin
        state_d = GAP;
        tcnt_d  = '0;
      end
      GAP: begin
        if (tick) begin
          if (tcnt_q == TW'(GAP_TICKS - 1)) begin
            state_d = enable ? LOAD : IDLE;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      phase_q  <= 1'b0;
      bit_q    <= '0;
      tcnt_q   <= '0;
      joy_clk  <= 1'b1;
      joy_load <= 1'b1;
      valid    <= 1'b0;
      raw_q    <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      tcnt_q   <= tcnt_d;
      joy_clk  <= !((state_d == SHIFT) && !phase_d);
      joy_load <= (state_d != LOAD);
      valid    <= (state_q == LATCH);
      if (sample) raw_q[bit_q] <= data_sync[1];
    end
  end

  always_comb begin
    for (int p = 0; p < PLAYERS; p++) begin
      dec_p[p]    = dec[p*BITS +: BITS];
      pres_new[p] = ~&dec_p[p];
      if (dec_p[p] != prev_q[p])   cnt_new[p] = 3'd0;
      else if (cnt_q[p] >= DEB_MAX) cnt_new[p] = DEB_MAX;
      else                          cnt_new[p] = cnt_q[p] + 3'd1;
    end
  end

  // An all-asserted word means a stuck or absent line: clear that player at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      joystick <= '0;
      present  <= '0;
      for (int p = 0; p < PLAYERS; p++) begin
        prev_q[p] <= '0;
        cnt_q[p]  <= '0;
      end
    end else if (state_q == LATCH) begin
      for (int p = 0; p < PLAYERS; p++) begin
        present[p] <= pres_new[p];
        prev_q[p]  <= dec_p[p];
        cnt_q[p]   <= cnt_new[p];
        if (!pres_new[p])              joystick[p*16 +: 16] <= 16'h0000;
        else if (cnt_new[p] == DEB_MAX) joystick[p*16 +: 16] <= 16'(dec_p[p]);
      end
    end
  end

endmodule

// File: tb/tb_joy_serial_multi.sv
// Bench for joy_serial_multi: a 74HC165 chain model feeds frames, and a
// frame-history model predicts the debounced buttons and presence flags.
module tb_joy_serial_multi;

  localparam int PLAYERS   = 2;
  localparam int BITS      = 12;
  localparam int CLK_DIV   = 4;
  localparam int GAP_TICKS = 8;
  localparam int DEB       = 2;
  localparam int FRAME_CLK = CLK_DIV * (2 + 2 * PLAYERS * BITS + GAP_TICKS) + 1;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        joy_data;
  logic        joy_clk;
  logic        joy_load;
  logic [31:0] joystick;
  logic [1:0]  present;
  logic        valid;

  int n_vec = 0;
  int n_err = 0;

  logic [23:0] pattern = '1;
  logic        tie_low = 1'b0;
  logic [23:0] chain   = '1;

  logic [23:0] hist[$];
  logic [31:0] m_joy;
  logic [1:0]  m_present;

  joy_serial_multi #(
    .PLAYERS(PLAYERS), .BITS(BITS), .CLK_DIV(CLK_DIV),
    .GAP_TICKS(GAP_TICKS), .DEBOUNCE(DEB), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .joy_data(joy_data),
    .joy_clk(joy_clk), .joy_load(joy_load), .joystick(joystick),
    .present(present), .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift register: parallel load while load is low, shift toward bit 0 on joy_clk rise.
  always @(negedge joy_load or posedge joy_clk) begin
    if (!joy_load) chain <= pattern;
    else           chain <= {1'b1, chain[23:1]};
  end
  assign joy_data = tie_low ? 1'b0 : chain[0];

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [23:0] cur_levels();
    return tie_low ? 24'h000000 : pattern;
  endfunction

  function automatic void model_reset();
    hist.delete();
    hist.push_back(24'h000000);
    m_joy     = '0;
    m_present = '0;
  endfunction

  // Output follows a player's word only once its last DEB frames agree.
  function automatic void model_frame(input logic [23:0] levels);
    logic [23:0] d;
    logic [11:0] dp;
    bit          same;
    d = ~levels;
    hist.push_back(d);
    while (hist.size() > DEB) void'(hist.pop_front());
    for (int p = 0; p < PLAYERS; p++) begin
      dp   = d[p*12 +: 12];
      same = (hist.size() == DEB);
      for (int k = 0; k < hist.size(); k++)
        if (hist[k][p*12 +: 12] != dp) same = 0;
      m_present[p] = (dp != 12'hFFF);
      if (!m_present[p]) m_joy[p*16 +: 16] = 16'h0000;
      else if (same)     m_joy[p*16 +: 16] = {4'h0, dp};
    end
  endfunction

  task automatic wait_valid(output bit ok, output int cyc);
    ok  = 0;
    cyc = 0;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (valid === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n, load_len, len, pulses, bad_low, bad_high, cyc;
    bit ok;
    reset_n = 1'b0;
    enable  = 1'b0;
    tie_low = 1'b0;
    pattern = '1;
    repeat (3) @(negedge clk);
    n_vec++; if (joy_clk !== 1'b1) begin n_err++; $display("[TB] FAIL reset_joy_clk: got %b expected 1", joy_clk); end
    n_vec++; if (joy_load !== 1'b1) begin n_err++; $display("[TB] FAIL reset_joy_load: got %b expected 1", joy_load); end
    n_vec++; if (joystick !== 32'h0) begin n_err++; $display("[TB] FAIL reset_joystick: got %h expected 0", joystick); end
    n_vec++; if (present !== 2'b00) begin n_err++; $display("[TB] FAIL reset_present: got %b expected 00", present); end
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
    model_reset();
    reset_n = 1'b1;
    enable  = 1'b1;
    n = 0;
    while (joy_load !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    load_len = 0;
    while (joy_load === 1'b0 && load_len < 40) begin @(negedge clk); load_len++; end
    n_vec++; if (load_len != 2 * CLK_DIV) begin n_err++; $display("[TB] FAIL load_width: got %0d clk expected %0d", load_len, 2 * CLK_DIV); end
    pulses = 0; bad_low = 0; bad_high = 0;
    for (int b = 0; b < PLAYERS * BITS; b++) begin
      len = 0;
      while (joy_clk === 1'b0 && len < 20) begin @(negedge clk); len++; end
      if (len > 0) pulses++;
      if (len != CLK_DIV) bad_low++;
      if (b < PLAYERS * BITS - 1) begin
        len = 0;
        while (joy_clk === 1'b1 && len < 20) begin @(negedge clk); len++; end
        if (len != CLK_DIV) bad_high++;
      end
    end
    n_vec++; if (pulses != PLAYERS * BITS) begin n_err++; $display("[TB] FAIL clk_pulses: got %0d expected %0d", pulses, PLAYERS * BITS); end
    n_vec++; if (bad_low != 0) begin n_err++; $display("[TB] FAIL clk_low_phase: got %0d bad phases expected 0", bad_low); end
    n_vec++; if (bad_high != 0) begin n_err++; $display("[TB] FAIL clk_high_phase: got %0d bad phases expected 0", bad_high); end
    wait_valid(ok, cyc);
    n_vec++; if (!ok) begin n_err++; $display("[TB] FAIL first_valid: got timeout expected strobe"); end
    model_frame(cur_levels());
    n_vec++; if (joystick !== m_joy) begin n_err++; $display("[TB] FAIL first_joystick: got %h expected %h", joystick, m_joy); end
    n_vec++; if (present !== m_present) begin n_err++; $display("[TB] FAIL first_present: got %b expected %b", present, m_present); end
  endtask

  task automatic test_datapath();
    int cyc;
    bit ok;
    pattern = ~{12'h800, 12'h011};
    for (int f = 0; f < 2; f++) begin
      wait_valid(ok, cyc);
      n_vec++; if (!ok) begin n_err++; $display("[TB] FAIL data_valid: got timeout expected strobe"); end
      n_vec++; if (cyc != FRAME_CLK) begin n_err++; $display("[TB] FAIL frame_period: got %0d clk expected %0d", cyc, FRAME_CLK); end
      model_frame(cur_levels());
      n_vec++; if (joystick !== m_joy) begin n_err++; $display("[TB] FAIL data_joystick: got %h expected %h", joystick, m_joy); end
      n_vec++; if (present !== m_present) begin n_err++; $display("[TB] FAIL data_present: got %b expected %b", present, m_present); end
    end
    n_vec++; if (joystick !== 32'h0800_0011) begin n_err++; $display("[TB] FAIL data_final: got %h expected 08000011", joystick); end
    n_vec++; if (present !== 2'b11) begin n_err++; $display("[TB] FAIL data_final_present: got %b expected 11", present); end
  endtask

  task automatic test_debounce();
    logic [11:0] seq [5];
    int cyc;
    bit ok;
    seq = '{12'h001, 12'h002, 12'h001, 12'h002, 12'h002};
    for (int f = 0; f < 5; f++) begin
      pattern = ~{12'h000, seq[f]};
      wait_valid(ok, cyc);
      n_vec++; if (!ok) begin n_err++; $display("[TB] FAIL deb_valid: got timeout expected strobe"); end
      model_frame(cur_levels());
      n_vec++; if (joystick !== m_joy) begin n_err++; $display("[TB] FAIL deb_joystick: got %h expected %h", joystick, m_joy); end
      if (f < 4) begin
        n_vec++; if (joystick[15:0] !== 16'h0011) begin n_err++; $display("[TB] FAIL deb_hold: got %h expected 0011", joystick[15:0]); end
      end else begin
        n_vec++; if (joystick[15:0] !== 16'h0002) begin n_err++; $display("[TB] FAIL deb_settle: got %h expected 0002", joystick[15:0]); end
      end
    end
  endtask

  task automatic test_disconnect();
    int cyc;
    bit ok;
    tie_low = 1'b1;
    wait_valid(ok, cyc);
    n_vec++; if (!ok) begin n_err++; $display("[TB] FAIL disc_valid: got timeout expected strobe"); end
    model_frame(cur_levels());
    n_vec++; if (present !== 2'b00) begin n_err++; $display("[TB] FAIL disc_present: got %b expected 00", present); end
    n_vec++; if (joystick !== 32'h0) begin n_err++; $display("[TB] FAIL disc_joystick: got %h expected 0", joystick); end
    tie_low = 1'b0;
    pattern = '1;
    wait_valid(ok, cyc);
    n_vec++; if (!ok) begin n_err++; $display("[TB] FAIL reconn_valid: got timeout expected strobe"); end
    model_frame(cur_levels());
    n_vec++; if (present !== 2'b11) begin n_err++; $display("[TB] FAIL reconn_present: got %b expected 11", present); end
    n_vec++; if (joystick !== m_joy || joystick !== 32'h0) begin n_err++; $display("[TB] FAIL reconn_joystick: got %h expected %h", joystick, m_joy); end
  endtask

  task automatic test_random();
    logic [23:0] lv;
    int r, cyc;
    bit ok;
    for (int f = 0; f < 20; f++) begin
      lv = pattern;
      for (int p = 0; p < PLAYERS; p++) begin
        r = $urandom_range(0, 9);
        if (r == 4)     lv[p*12 +: 12] = 12'h000;
        else if (r > 4) lv[p*12 +: 12] = 12'($urandom);
      end
      pattern = lv;
      wait_valid(ok, cyc);
      n_vec++; if (!ok) begin n_err++; $display("[TB] FAIL rand_valid: got timeout expected strobe"); end
      model_frame(cur_levels());
      n_vec++; if (joystick !== m_joy) begin n_err++; $display("[TB] FAIL rand_joystick frame %0d: got %h expected %h", f, joystick, m_joy); end
      n_vec++; if (present !== m_present) begin n_err++; $display("[TB] FAIL rand_present frame %0d: got %b expected %b", f, present, m_present); end
    end
  endtask

  task automatic test_enable_drop();
    int n, cyc, vcount, lcount, ccount;
    bit ok;
    pattern = ~{12'h3C0, 12'h00F};
    n = 0;
    while (joy_load !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    n = 0;
    while (joy_load === 1'b0 && n < 20) begin @(negedge clk); n++; end
    for (int b = 0; b < 10; b++) begin
      n = 0;
      while (joy_clk === 1'b0 && n < 20) begin @(negedge clk); n++; end
      n = 0;
      while (joy_clk === 1'b1 && n < 20) begin @(negedge clk); n++; end
    end
    enable = 1'b0;
    wait_valid(ok, cyc);
    n_vec++; if (!ok) begin n_err++; $display("[TB] FAIL drop_valid: got timeout expected strobe"); end
    model_frame(cur_levels());
    n_vec++; if (joystick !== m_joy) begin n_err++; $display("[TB] FAIL drop_joystick: got %h expected %h", joystick, m_joy); end
    vcount = 0; lcount = 0; ccount = 0;
    repeat (300) begin
      @(negedge clk);
      if (valid === 1'b1) vcount++;
      if (joy_load !== 1'b1) lcount++;
      if (joy_clk !== 1'b1) ccount++;
    end
    n_vec++; if (vcount != 0) begin n_err++; $display("[TB] FAIL park_valid: got %0d extra strobes expected 0", vcount); end
    n_vec++; if (lcount != 0) begin n_err++; $display("[TB] FAIL park_load: got %0d low clk expected 0", lcount); end
    n_vec++; if (ccount != 0) begin n_err++; $display("[TB] FAIL park_clk: got %0d low clk expected 0", ccount); end
    enable = 1'b1;
    @(posedge clk);
    #1;
    n_vec++; if (joy_load !== 1'b0) begin n_err++; $display("[TB] FAIL restart_load: got %b expected 0", joy_load); end
    wait_valid(ok, cyc);
    n_vec++; if (!ok) begin n_err++; $display("[TB] FAIL restart_valid: got timeout expected strobe"); end
    model_frame(cur_levels());
    n_vec++; if (joystick !== m_joy) begin n_err++; $display("[TB] FAIL restart_joystick: got %h expected %h", joystick, m_joy); end
  endtask

  task automatic test_reset_mid();
    int n, load_len, cyc;
    bit ok;
    pattern = ~{12'hFFF, 12'h5A5};
    n = 0;
    while (joy_load !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    repeat (30) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_vec++; if (joy_clk !== 1'b1) begin n_err++; $display("[TB] FAIL mid_joy_clk: got %b expected 1", joy_clk); end
    n_vec++; if (joy_load !== 1'b1) begin n_err++; $display("[TB] FAIL mid_joy_load: got %b expected 1", joy_load); end
    n_vec++; if (joystick !== 32'h0) begin n_err++; $display("[TB] FAIL mid_joystick: got %h expected 0", joystick); end
    n_vec++; if (present !== 2'b00) begin n_err++; $display("[TB] FAIL mid_present: got %b expected 00", present); end
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("[TB] FAIL mid_valid: got %b expected 0", valid); end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    n = 0;
    while (joy_load !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    load_len = 0;
    while (joy_load === 1'b0 && load_len < 40) begin @(negedge clk); load_len++; end
    n_vec++; if (load_len != 2 * CLK_DIV) begin n_err++; $display("[TB] FAIL mid_load_width: got %0d clk expected %0d", load_len, 2 * CLK_DIV); end
    for (int f = 0; f < 2; f++) begin
      wait_valid(ok, cyc);
      n_vec++; if (!ok) begin n_err++; $display("[TB] FAIL mid_frame_valid: got timeout expected strobe"); end
      model_frame(cur_levels());
      n_vec++; if (joystick !== m_joy) begin n_err++; $display("[TB] FAIL mid_frame_joystick: got %h expected %h", joystick, m_joy); end
      n_vec++; if (present !== 2'b01) begin n_err++; $display("[TB] FAIL mid_frame_present: got %b expected 01", present); end
    end
    n_vec++; if (joystick !== 32'h0000_05A5) begin n_err++; $display("[TB] FAIL mid_frame_final: got %h expected 000005a5", joystick); end
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    test_reset();
    test_datapath();
    test_debounce();
    test_disconnect();
    test_random();
    test_enable_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
